// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage with an integrated load/store unit and a
// word-organised data RAM. Decodes byte/half/word accesses, flags misaligned
// ones, inserts WAIT_STATES stall cycles per aligned access and registers the
// MEM/WB slot (write-back mux included).
//
// Stall handshake: stall is combinational. While stall=1 the upstream stage
// must hold every input stable; the access is performed on the cycle stall
// drops back to 0 (or at once when WAIT_STATES=0), and the result appears on
// the MEM/WB outputs one cycle later with valid_out=1.
module mem_stage_lsu #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            werf,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] ex_result,
    input  logic [4:0]      rd_in,
    output logic            stall,
    output logic            valid_out,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      rd_out,
    output logic            werf_out,
    output logic            misaligned,
    output logic            dbg_busy_o,
    output logic [3:0]      dbg_cnt_o
);

    localparam int AW      = $clog2(DEPTH);
    localparam int WS_INIT = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0] CNT_INIT = 4'(WS_INIT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Access size codes: 00 byte, 01 half, 10 word
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] wb_q, wb_d;
    logic [4:0]      rd_q, rd_d;
    logic            werf_q, werf_d;
    logic            mis_q, mis_d;

    logic [XLEN-1:0] mem_q [DEPTH];

    logic            mem_op;
    logic            is_load;
    logic [1:0]      size;
    logic            unsigned_ld;
    logic            addr_mis;
    logic            aligned_op;
    logic            mis_op;
    logic [1:0]      boff;
    logic [AW-1:0]   widx;
    logic [XLEN-1:0] rword;
    logic [7:0]      rbyte;
    logic [15:0]     rhalf;
    logic [XLEN-1:0] load_val;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata;
    logic            do_access;
    logic            retire;
    logic            unused_addr;

    // Upper address bits beyond the RAM index are intentionally ignored (wrap-around)
    assign unused_addr = ^addr[XLEN-1:AW+2];

    assign mem_op      = valid_in & (mem_read | mem_write);
    assign is_load     = mem_read & ~mem_write;
    assign size        = (funct3[1:0] == 2'b11) ? SZ_W : funct3[1:0];
    assign unsigned_ld = funct3[2];
    assign boff        = addr[1:0];
    assign widx        = addr[AW+1:2];
    assign rword       = mem_q[widx];

    // Alignment check: halves need addr[0]=0, words need addr[1:0]=0
    always_comb begin
        addr_mis = 1'b0;
        case (size)
            SZ_H:    addr_mis = addr[0];
            SZ_W:    addr_mis = (addr[1:0] != 2'b00);
            default: addr_mis = 1'b0;
        endcase
    end

    assign aligned_op = mem_op & ~addr_mis;
    assign mis_op     = mem_op & addr_mis;

    // Load path: pick byte/half out of the word and sign- or zero-extend it
    always_comb begin
        rbyte    = rword[{boff, 3'b000} +: 8];
        rhalf    = addr[1] ? rword[31:16] : rword[15:0];
        load_val = rword;
        case (size)
            SZ_B: load_val = unsigned_ld ? {{(XLEN-8){1'b0}}, rbyte}
                                         : {{(XLEN-8){rbyte[7]}}, rbyte};
            SZ_H: load_val = unsigned_ld ? {{(XLEN-16){1'b0}}, rhalf}
                                         : {{(XLEN-16){rhalf[15]}}, rhalf};
            default: load_val = rword;
        endcase
    end

    // Store path: byte enables from size/offset, data replicated across lanes
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = store_data;
        case (size)
            SZ_B: begin
                st_be    = 4'b0001 << boff;
                st_wdata = {4{store_data[7:0]}};
            end
            SZ_H: begin
                st_be    = addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{store_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = store_data;
            end
        endcase
    end

    // Next-state, stall and MEM/WB slot decode for the IDLE/BUSY access FSM
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall     = 1'b0;
        do_access = 1'b0;
        retire    = 1'b0;
        valid_d   = 1'b0;
        mis_d     = 1'b0;
        wb_d      = wb_q;
        rd_d      = rd_q;
        werf_d    = werf_q;

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (mis_op) begin
                        // Exception slot: no RAM access, no stall, no register write
                        valid_d = 1'b1;
                        mis_d   = 1'b1;
                        werf_d  = 1'b0;
                        wb_d    = '0;
                        rd_d    = rd_in;
                    end else if (aligned_op) begin
                        if (WAIT_STATES == 0) begin
                            do_access = 1'b1;
                            retire    = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            cnt_d   = CNT_INIT;
                            state_d = BUSY;
                        end
                    end else begin
                        retire = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Inputs have been held by upstream; access them now
                    do_access = 1'b1;
                    retire    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        if (retire) begin
            valid_d = 1'b1;
            wb_d    = (mem_op && is_load) ? load_val : ex_result;
            rd_d    = rd_in;
            werf_d  = werf;
        end
    end

    // FSM state, wait counter and MEM/WB register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            valid_q <= 1'b0;
            wb_q    <= '0;
            rd_q    <= 5'd0;
            werf_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            wb_q    <= wb_d;
            rd_q    <= rd_d;
            werf_q  <= werf_d;
            mis_q   <= mis_d;
        end
    end

    // Byte-lane RAM write on the access edge; suppressed while reset is held
    always_ff @(posedge clk) begin
        if (rst_n && do_access && mem_write) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) begin
                    mem_q[widx][8*b +: 8] <= st_wdata[8*b +: 8];
                end
            end
        end
    end

    assign valid_out  = valid_q;
    assign wb_data    = wb_q;
    assign rd_out     = rd_q;
    assign werf_out   = werf_q;
    assign misaligned = mis_q;
    assign dbg_busy_o = (state_q == BUSY);
    assign dbg_cnt_o  = cnt_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed bench for mem_stage_lsu. Three instances with
// WAIT_STATES = 0, 2 and 3 share one clock; each has its own inputs and reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_stage_lsu;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    // Instance index: 0 -> WAIT_STATES=0, 1 -> 2, 2 -> 3
    localparam int K0 = 0;
    localparam int K2 = 1;
    localparam int K3 = 2;

    logic        clk;
    logic        rst_n_a [3];
    logic        v_in    [3];
    logic        rd_en   [3];
    logic        wr_en   [3];
    logic        we_in   [3];
    logic [2:0]  f3_in   [3];
    logic [31:0] addr_in [3];
    logic [31:0] sd_in   [3];
    logic [31:0] ex_in   [3];
    logic [4:0]  rdi     [3];

    logic        stall_o [3];
    logic        vo      [3];
    logic [31:0] wb_o    [3];
    logic [4:0]  rdo     [3];
    logic        werfo   [3];
    logic        mis_o   [3];
    logic        busy_o  [3];
    logic [3:0]  cnt_o   [3];

    int n_cmp  = 0;
    int n_fail = 0;

    // Clock: 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_stage_lsu #(.XLEN(32), .DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n_a[0]), .valid_in(v_in[0]), .mem_read(rd_en[0]),
        .mem_write(wr_en[0]), .werf(we_in[0]), .funct3(f3_in[0]), .addr(addr_in[0]),
        .store_data(sd_in[0]), .ex_result(ex_in[0]), .rd_in(rdi[0]),
        .stall(stall_o[0]), .valid_out(vo[0]), .wb_data(wb_o[0]), .rd_out(rdo[0]),
        .werf_out(werfo[0]), .misaligned(mis_o[0]), .dbg_busy_o(busy_o[0]),
        .dbg_cnt_o(cnt_o[0])
    );

    mem_stage_lsu #(.XLEN(32), .DEPTH(1024), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst_n(rst_n_a[1]), .valid_in(v_in[1]), .mem_read(rd_en[1]),
        .mem_write(wr_en[1]), .werf(we_in[1]), .funct3(f3_in[1]), .addr(addr_in[1]),
        .store_data(sd_in[1]), .ex_result(ex_in[1]), .rd_in(rdi[1]),
        .stall(stall_o[1]), .valid_out(vo[1]), .wb_data(wb_o[1]), .rd_out(rdo[1]),
        .werf_out(werfo[1]), .misaligned(mis_o[1]), .dbg_busy_o(busy_o[1]),
        .dbg_cnt_o(cnt_o[1])
    );

    mem_stage_lsu #(.XLEN(32), .DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst_n(rst_n_a[2]), .valid_in(v_in[2]), .mem_read(rd_en[2]),
        .mem_write(wr_en[2]), .werf(we_in[2]), .funct3(f3_in[2]), .addr(addr_in[2]),
        .store_data(sd_in[2]), .ex_result(ex_in[2]), .rd_in(rdi[2]),
        .stall(stall_o[2]), .valid_out(vo[2]), .wb_data(wb_o[2]), .rd_out(rdo[2]),
        .werf_out(werfo[2]), .misaligned(mis_o[2]), .dbg_busy_o(busy_o[2]),
        .dbg_cnt_o(cnt_o[2])
    );

    // Driver: present one instruction in the EX/MEM slot of instance k
    task automatic drive(input int k, input logic rd, input logic wr, input logic we,
                         input logic [2:0] fn, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] ex, input logic [4:0] r);
        v_in[k]    = 1'b1;
        rd_en[k]   = rd;
        wr_en[k]   = wr;
        we_in[k]   = we;
        f3_in[k]   = fn;
        addr_in[k] = a;
        sd_in[k]   = sd;
        ex_in[k]   = ex;
        rdi[k]     = r;
    endtask

    // Driver: empty EX/MEM slot for instance k
    task automatic idle(input int k);
        v_in[k]    = 1'b0;
        rd_en[k]   = 1'b0;
        wr_en[k]   = 1'b0;
        we_in[k]   = 1'b0;
        f3_in[k]   = 3'b000;
        addr_in[k] = 32'h0;
        sd_in[k]   = 32'h0;
        ex_in[k]   = 32'h0;
        rdi[k]     = 5'd0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            rst_n_a[k] = 1'b0;
            idle(k);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({vo[k], wb_o[k], rdo[k], werfo[k], mis_o[k], busy_o[k], cnt_o[k]} !== 45'd0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got v=%b wb=%h rd=%0d we=%b mis=%b busy=%b cnt=%0d, want all 0",
                         k, vo[k], wb_o[k], rdo[k], werfo[k], mis_o[k], busy_o[k], cnt_o[k]);
            end
        end
        for (int k = 0; k < 3; k++) rst_n_a[k] = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load_ws0();
        drive(K0, 1'b0, 1'b1, 1'b0, F_W, 32'h10, 32'hDEADBEEF, 32'h0000_0010, 5'd0);
        #1;
        n_cmp++;
        if (stall_o[K0] !== 1'b0) begin
            n_fail++; $display("FAIL ws0_sw_stall: got %b want 0", stall_o[K0]);
        end
        @(negedge clk);
        n_cmp++;
        if ({vo[K0], werfo[K0], mis_o[K0], wb_o[K0]} !== {3'b100, 32'h0000_0010}) begin
            n_fail++;
            $display("FAIL ws0_sw_retire: got v=%b we=%b mis=%b wb=%h want v=1 we=0 mis=0 wb=00000010",
                     vo[K0], werfo[K0], mis_o[K0], wb_o[K0]);
        end
        drive(K0, 1'b1, 1'b0, 1'b1, F_W, 32'h10, 32'h0, 32'h0, 5'd5);
        #1;
        n_cmp++;
        if (stall_o[K0] !== 1'b0) begin
            n_fail++; $display("FAIL ws0_lw_stall: got %b want 0", stall_o[K0]);
        end
        @(negedge clk);
        n_cmp++;
        if ({vo[K0], wb_o[K0], rdo[K0], werfo[K0]} !== {1'b1, 32'hDEADBEEF, 5'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL ws0_lw_data: got v=%b wb=%h rd=%0d we=%b want v=1 wb=deadbeef rd=5 we=1",
                     vo[K0], wb_o[K0], rdo[K0], werfo[K0]);
        end
        idle(K0);
        @(negedge clk);
        n_cmp++;
        if (vo[K0] !== 1'b0) begin
            n_fail++; $display("FAIL ws0_idle_valid: got %b want 0", vo[K0]);
        end
    endtask

    task automatic test_byte_half();
        drive(K0, 1'b0, 1'b1, 1'b0, F_W, 32'h10, 32'h11223344, 32'h0, 5'd0);
        @(negedge clk);
        drive(K0, 1'b0, 1'b1, 1'b0, F_B, 32'h13, 32'hABCDEF80, 32'h0, 5'd0);
        @(negedge clk);
        drive(K0, 1'b1, 1'b0, 1'b1, F_B, 32'h13, 32'h0, 32'h0, 5'd1);
        @(negedge clk);
        n_cmp++;
        if (wb_o[K0] !== 32'hFFFFFF80) begin
            n_fail++; $display("FAIL lb_sext: got %h want ffffff80", wb_o[K0]);
        end
        drive(K0, 1'b1, 1'b0, 1'b1, F_BU, 32'h13, 32'h0, 32'h0, 5'd2);
        @(negedge clk);
        n_cmp++;
        if (wb_o[K0] !== 32'h00000080) begin
            n_fail++; $display("FAIL lbu_zext: got %h want 00000080", wb_o[K0]);
        end
        drive(K0, 1'b1, 1'b0, 1'b1, F_HU, 32'h10, 32'h0, 32'h0, 5'd3);
        @(negedge clk);
        n_cmp++;
        if (wb_o[K0] !== 32'h00003344) begin
            n_fail++; $display("FAIL lhu_low: got %h want 00003344", wb_o[K0]);
        end
        drive(K0, 1'b1, 1'b0, 1'b1, F_H, 32'h12, 32'h0, 32'h0, 5'd4);
        @(negedge clk);
        n_cmp++;
        if (wb_o[K0] !== 32'hFFFF8022) begin
            n_fail++; $display("FAIL lh_high_sext: got %h want ffff8022", wb_o[K0]);
        end
        drive(K0, 1'b0, 1'b1, 1'b0, F_H, 32'h12, 32'h1234BEEF, 32'h0, 5'd0);
        @(negedge clk);
        drive(K0, 1'b1, 1'b0, 1'b1, F_W, 32'h10, 32'h0, 32'h0, 5'd6);
        @(negedge clk);
        n_cmp++;
        if (wb_o[K0] !== 32'hBEEF3344) begin
            n_fail++; $display("FAIL sh_upper_lanes: got %h want beef3344", wb_o[K0]);
        end
        drive(K0, 1'b1, 1'b0, 1'b1, F_B, 32'h11, 32'h0, 32'h0, 5'd7);
        @(negedge clk);
        n_cmp++;
        if (wb_o[K0] !== 32'h00000033) begin
            n_fail++; $display("FAIL lb_lane1: got %h want 00000033", wb_o[K0]);
        end
        idle(K0);
        @(negedge clk);
    endtask

    task automatic test_wait_states();
        // Op 0: SW 0xCAFEF00D @0x30, op 1: LW @0x30; both on the WAIT_STATES=3 instance
        for (int op = 0; op < 2; op++) begin
            if (op == 0) drive(K3, 1'b0, 1'b1, 1'b0, F_W, 32'h30, 32'hCAFEF00D, 32'h0, 5'd0);
            else         drive(K3, 1'b1, 1'b0, 1'b1, F_W, 32'h30, 32'h0, 32'h0, 5'd12);
            #1;
            n_cmp++;
            if (stall_o[K3] !== 1'b1) begin
                n_fail++; $display("FAIL ws3_stall_t op%0d: got %b want 1", op, stall_o[K3]);
            end
            for (int i = 1; i <= 3; i++) begin
                @(negedge clk);
                n_cmp++;
                if ({stall_o[K3], vo[K3]} !== {(i <= 2), 1'b0}) begin
                    n_fail++;
                    $display("FAIL ws3_stall_t+%0d op%0d: got stall=%b v=%b want stall=%b v=0",
                             i, op, stall_o[K3], vo[K3], (i <= 2));
                end
            end
            @(negedge clk);
            n_cmp++;
            if (vo[K3] !== 1'b1) begin
                n_fail++; $display("FAIL ws3_valid_t+4 op%0d: got %b want 1", op, vo[K3]);
            end
        end
        n_cmp++;
        if ({wb_o[K3], rdo[K3], werfo[K3]} !== {32'hCAFEF00D, 5'd12, 1'b1}) begin
            n_fail++;
            $display("FAIL ws3_lw_data: got wb=%h rd=%0d we=%b want cafef00d rd=12 we=1",
                     wb_o[K3], rdo[K3], werfo[K3]);
        end
        idle(K3);
        @(negedge clk);
    endtask

    task automatic test_misalign();
        // LH @0x21, LW @0x22, SW @0x31, SH @0x33: all misaligned on the WAIT_STATES=3 instance
        for (int j = 0; j < 4; j++) begin
            case (j)
                0: drive(K3, 1'b1, 1'b0, 1'b1, F_H, 32'h21, 32'h0, 32'h777, 5'd9);
                1: drive(K3, 1'b1, 1'b0, 1'b1, F_W, 32'h22, 32'h0, 32'h777, 5'd10);
                2: drive(K3, 1'b0, 1'b1, 1'b1, F_W, 32'h31, 32'hFFFFFFFF, 32'h777, 5'd11);
                default: drive(K3, 1'b0, 1'b1, 1'b1, F_H, 32'h33, 32'hFFFFFFFF, 32'h777, 5'd13);
            endcase
            #1;
            n_cmp++;
            if (stall_o[K3] !== 1'b0) begin
                n_fail++; $display("FAIL mis_stall[%0d]: got %b want 0", j, stall_o[K3]);
            end
            @(negedge clk);
            n_cmp++;
            if ({vo[K3], mis_o[K3], werfo[K3], wb_o[K3]} !== {3'b110, 32'h0}) begin
                n_fail++;
                $display("FAIL mis_flag[%0d]: got v=%b mis=%b we=%b wb=%h want v=1 mis=1 we=0 wb=0",
                         j, vo[K3], mis_o[K3], werfo[K3], wb_o[K3]);
            end
        end
        idle(K3);
        @(negedge clk);
        n_cmp++;
        if ({vo[K3], mis_o[K3]} !== 2'b00) begin
            n_fail++; $display("FAIL mis_clear: got v=%b mis=%b want 0 0", vo[K3], mis_o[K3]);
        end
        drive(K3, 1'b1, 1'b0, 1'b1, F_W, 32'h30, 32'h0, 32'h0, 5'd14);
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({vo[K3], mis_o[K3], wb_o[K3]} !== {2'b10, 32'hCAFEF00D}) begin
            n_fail++;
            $display("FAIL mis_no_write: got v=%b mis=%b wb=%h want v=1 mis=0 wb=cafef00d",
                     vo[K3], mis_o[K3], wb_o[K3]);
        end
        idle(K3);
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        drive(K2, 1'b0, 1'b1, 1'b1, F_W, 32'h40, 32'h11112222, 32'h99, 5'd3);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({vo[K2], wb_o[K2]} !== {1'b1, 32'h99}) begin
            n_fail++; $display("FAIL ws2_first_sw: got v=%b wb=%h want v=1 wb=00000099", vo[K2], wb_o[K2]);
        end
        drive(K2, 1'b0, 1'b1, 1'b1, F_W, 32'h40, 32'hAAAA5555, 32'h55, 5'd4);
        @(negedge clk);
        n_cmp++;
        if ({stall_o[K2], busy_o[K2], vo[K2]} !== 3'b110) begin
            n_fail++;
            $display("FAIL ws2_busy: got stall=%b busy=%b v=%b want 1 1 0", stall_o[K2], busy_o[K2], vo[K2]);
        end
        #1;
        rst_n_a[K2] = 1'b0;
        idle(K2);
        #1;
        n_cmp++;
        if ({vo[K2], wb_o[K2], rdo[K2], werfo[K2], mis_o[K2], busy_o[K2]} !== 41'd0) begin
            n_fail++;
            $display("FAIL ws2_async_reset: got v=%b wb=%h rd=%0d we=%b mis=%b busy=%b want all 0",
                     vo[K2], wb_o[K2], rdo[K2], werfo[K2], mis_o[K2], busy_o[K2]);
        end
        repeat (2) @(negedge clk);
        rst_n_a[K2] = 1'b1;
        drive(K2, 1'b1, 1'b0, 1'b1, F_W, 32'h40, 32'h0, 32'h0, 5'd6);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({vo[K2], wb_o[K2]} !== {1'b1, 32'h11112222}) begin
            n_fail++;
            $display("FAIL ws2_store_aborted: got v=%b wb=%h want v=1 wb=11112222", vo[K2], wb_o[K2]);
        end
        idle(K2);
        @(negedge clk);
    endtask

    task automatic test_alu_alias();
        drive(K0, 1'b0, 1'b0, 1'b1, F_W, 32'h11, 32'h0, 32'h1234, 5'd7);
        #1;
        n_cmp++;
        if (stall_o[K0] !== 1'b0) begin
            n_fail++; $display("FAIL alu_stall: got %b want 0", stall_o[K0]);
        end
        @(negedge clk);
        n_cmp++;
        if ({vo[K0], wb_o[K0], rdo[K0], werfo[K0], mis_o[K0]} !== {1'b1, 32'h1234, 5'd7, 2'b10}) begin
            n_fail++;
            $display("FAIL alu_pass: got v=%b wb=%h rd=%0d we=%b mis=%b want 1 00001234 7 1 0",
                     vo[K0], wb_o[K0], rdo[K0], werfo[K0], mis_o[K0]);
        end
        drive(K0, 1'b0, 1'b0, 1'b0, F_B, 32'h0, 32'h0, 32'hFFFF0000, 5'd31);
        @(negedge clk);
        n_cmp++;
        if ({wb_o[K0], rdo[K0], werfo[K0]} !== {32'hFFFF0000, 5'd31, 1'b0}) begin
            n_fail++;
            $display("FAIL alu_back_to_back: got wb=%h rd=%0d we=%b want ffff0000 31 0",
                     wb_o[K0], rdo[K0], werfo[K0]);
        end
        // Store at 4*DEPTH+8 must land in word 2
        drive(K0, 1'b0, 1'b1, 1'b0, F_W, 32'h0000_1008, 32'h5A5A0F0F, 32'h0, 5'd0);
        @(negedge clk);
        drive(K0, 1'b1, 1'b0, 1'b1, F_W, 32'h0000_0008, 32'h0, 32'h0, 5'd8);
        @(negedge clk);
        n_cmp++;
        if (wb_o[K0] !== 32'h5A5A0F0F) begin
            n_fail++; $display("FAIL addr_alias: got %h want 5a5a0f0f", wb_o[K0]);
        end
        // Both read and write set: treated as a store, wb_data carries ex_result
        drive(K0, 1'b1, 1'b1, 1'b1, F_W, 32'h0000_2008, 32'h01020304, 32'h77, 5'd9);
        @(negedge clk);
        n_cmp++;
        if (wb_o[K0] !== 32'h77) begin
            n_fail++; $display("FAIL rw_is_store_wb: got %h want 00000077", wb_o[K0]);
        end
        drive(K0, 1'b1, 1'b0, 1'b1, F_W, 32'h0000_0008, 32'h0, 32'h0, 5'd10);
        @(negedge clk);
        n_cmp++;
        if (wb_o[K0] !== 32'h01020304) begin
            n_fail++; $display("FAIL rw_is_store_mem: got %h want 01020304", wb_o[K0]);
        end
        idle(K0);
        @(negedge clk);
    endtask

    // Watchdog: the directed sequence is a few hundred cycles at most
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_store_load_ws0();
        test_byte_half();
        test_wait_states();
        test_misalign();
        test_reset_abort();
        test_alu_alias();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
